sargantana_idata_sched: RTL and testbench
=========================================

Name: sargantana_idata_sched

Overview:
- Access scheduler for the instruction-cache data memory array (one bank per way, shared address/data/write-enable, per-way request).
- Shares the single array port between fetch lookups (read all ways) and line refills (write one victim way).
- Buffers one refill line, picks the victim way round-robin, and bounds fetch-over-refill priority with a starvation counter.
- Sits between the icache control FSM/fetch stage and the data memory array.

Parameters:
ICACHE_N_WAY, 4, number of ways (power of 2, >=2)
SET_WIDHT, 256, line width in bits
ADDR_WIDHT, 6, set index width
MAX_WAIT, 4, cycles a buffered refill may be deferred by fetches before forced grant (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
fetch_valid_i  in  1  fetch lookup request
fetch_addr_i  in  ADDR_WIDHT  fetch set index
fetch_ready_o  out  1  fetch lookup issued this cycle
fetch_rvalid_o  out  1  lookup data valid (one cycle after issue)
fetch_data_o  out  ICACHE_N_WAY*SET_WIDHT  per-way line data
refill_valid_i  in  1  refill line offered
refill_addr_i  in  ADDR_WIDHT  refill set index
refill_data_i  in  SET_WIDHT  refill line
refill_ready_o  out  1  refill buffer empty, line accepted
refill_way_o  out  ICACHE_N_WAY  one-hot victim way of buffered line (for tag update)
refill_done_o  out  1  pulse: buffered line written to array
flush_i  in  1  synchronous flush: drop buffer, reset victim pointer
mem_req_o  out  ICACHE_N_WAY  per-way request to array
mem_we_o  out  1  array write enable
mem_addr_o  out  ADDR_WIDHT  array set index
mem_data_o  out  SET_WIDHT  array write data
mem_data_i  in  ICACHE_N_WAY*SET_WIDHT  array read data

Behaviour:
- Reset: buffer EMPTY, victim pointer 0, starve_cnt 0, fetch_rvalid_o 0, refill_done_o 0; refill_ready_o 1; mem_req_o 0, mem_we_o 0.
- Refill buffer FSM: EMPTY -> FULL on refill_valid_i & refill_ready_o (capture addr, data, and victim one-hot from pointer). FULL -> EMPTY on write grant. refill_ready_o = (state==EMPTY) & !flush_i.
- Victim pointer: increments mod ICACHE_N_WAY on each write grant; refill_way_o = one-hot(latched victim) while FULL, 0 when EMPTY.
- Arbitration (combinational, per cycle, flush_i=0):
  - write_sel = FULL & (!fetch_valid_i | starve_cnt==MAX_WAIT).
  - read_sel = fetch_valid_i & !write_sel.
  - write_sel: mem_req_o = victim one-hot, mem_we_o=1, mem_addr_o/mem_data_o from buffer, refill_done_o=1 next cycle.
  - read_sel: mem_req_o = all ones, mem_we_o=0, mem_addr_o=fetch_addr_i, fetch_ready_o=1.
  - neither: mem_req_o=0, mem_we_o=0.
- starve_cnt: +1 when FULL and write not selected (saturates at MAX_WAIT); cleared on write grant or EMPTY.
- Read latency 1: fetch_rvalid_o registered = read_sel; fetch_data_o = mem_data_i passthrough, valid only while fetch_rvalid_o. Back-to-back reads every cycle allowed.
- Refill accepted in cycle N is writable earliest N+1; a refill and a fetch to the same set in one cycle: fetch reads old contents (no bypass).
- flush_i: that cycle mem_req_o=0, fetch_ready_o=0; next cycle buffer EMPTY, pointer 0, starve_cnt 0; pending fetch_rvalid_o from the previous cycle still asserted.
- Reset mid-operation: all state to reset values immediately; buffered line discarded, no write issued.

Optional Feature:
- SARGANTANA_IDATA_SCHED_PERF_EN: adds outputs perf_fetch_stall_o (32-bit, counts cycles fetch_valid_i=1 & fetch_ready_o=0) and perf_refill_wr_o (32-bit, counts write grants); both wrap, clear on reset/flush_i.
- Without macro: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then fetch_valid_i=1, addr 0x05 -> same cycle mem_req_o=4'b1111, mem_we_o=0, mem_addr_o=5; next cycle fetch_rvalid_o=1, fetch_data_o=mem_data_i.
- Refill addr 0x0A with fetch idle -> accepted cycle N, write cycle N+1 to way 0 (mem_req_o=4'b0001, mem_we_o=1), refill_done_o at N+2; next refill goes to way 1.
- Continuous fetch_valid_i with buffered refill, MAX_WAIT=4 -> 4 fetches granted, 5th cycle write forced, fetch_ready_o=0 that cycle, fetch resumes after.
- Five refills, no fetches -> victim ways 0,1,2,3,0; refill_ready_o low exactly while FULL.
- flush_i while FULL -> no write issued, refill_ready_o=1 next cycle, next refill uses way 0.
- Assert rst_i with buffer FULL and read in flight -> fetch_rvalid_o=0, mem_req_o=0, refill_ready_o=1 immediately; no write after release.

Source files
------------

// File: rtl/sargantana_idata_sched.sv
// Instruction-cache data array scheduler: single port shared by fetch reads and buffered refill writes.
// Optional perf counters enabled with SARGANTANA_IDATA_SCHED_PERF_EN.
module sargantana_idata_sched #(
  parameter int unsigned ICACHE_N_WAY = 4,
  parameter int unsigned SET_WIDHT    = 256,
  parameter int unsigned ADDR_WIDHT   = 6,
  parameter int unsigned MAX_WAIT     = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               fetch_valid_i,
  input  logic [ADDR_WIDHT-1:0]              fetch_addr_i,
  output logic                               fetch_ready_o,
  output logic                               fetch_rvalid_o,
  output logic [ICACHE_N_WAY*SET_WIDHT-1:0]  fetch_data_o,
  input  logic                               refill_valid_i,
  input  logic [ADDR_WIDHT-1:0]              refill_addr_i,
  input  logic [SET_WIDHT-1:0]               refill_data_i,
  output logic                               refill_ready_o,
  output logic [ICACHE_N_WAY-1:0]            refill_way_o,
  output logic                               refill_done_o,
  input  logic                               flush_i,
  output logic [ICACHE_N_WAY-1:0]            mem_req_o,
  output logic                               mem_we_o,
  output logic [ADDR_WIDHT-1:0]              mem_addr_o,
  output logic [SET_WIDHT-1:0]               mem_data_o,
  input  logic [ICACHE_N_WAY*SET_WIDHT-1:0]  mem_data_i
`ifdef SARGANTANA_IDATA_SCHED_PERF_EN
  ,
  output logic [31:0]                        perf_fetch_stall_o,
  output logic [31:0]                        perf_refill_wr_o
`endif
);

  localparam int unsigned PTR_W = $clog2(ICACHE_N_WAY);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t              state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [ICACHE_N_WAY-1:0] vic_q, vic_d;
  logic [CNT_W-1:0]        starve_q, starve_d;
  logic [ADDR_WIDHT-1:0]   buf_addr_q;
  logic [SET_WIDHT-1:0]    buf_data_q;
  logic                    rvalid_q;
  logic                    done_q;
  logic                    write_sel;
  logic                    read_sel;
  logic                    refill_accept;

  // rst_i gates the grants so the array sees no request while reset is held
  always_comb begin
    write_sel = (state_q == FULL) & ~flush_i & ~rst_i &
                (~fetch_valid_i | (starve_q == CNT_W'(MAX_WAIT)));
    read_sel  = fetch_valid_i & ~write_sel & ~flush_i & ~rst_i;
  end

  assign refill_ready_o = (state_q == EMPTY) & ~flush_i;
  assign refill_accept  = refill_ready_o & refill_valid_i;
  assign refill_way_o   = (state_q == FULL) ? vic_q : '0;
  assign fetch_ready_o  = read_sel;
  assign fetch_rvalid_o = rvalid_q;
  assign fetch_data_o   = mem_data_i;
  assign refill_done_o  = done_q;
  assign mem_req_o      = write_sel ? vic_q : (read_sel ? '1 : '0);
  assign mem_we_o       = write_sel;
  assign mem_addr_o     = write_sel ? buf_addr_q : fetch_addr_i;
  assign mem_data_o     = buf_data_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    vic_d    = vic_q;
    starve_d = starve_q;
    if (flush_i) begin
      state_d  = EMPTY;
      ptr_d    = '0;
      starve_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          starve_d = '0;
          if (refill_valid_i) begin
            state_d = FULL;
            vic_d   = ICACHE_N_WAY'(1) << ptr_q;
          end
        end
        FULL: begin
          if (write_sel) begin
            state_d  = EMPTY;
            ptr_d    = ptr_q + PTR_W'(1);
            starve_d = '0;
          end else if (starve_q != CNT_W'(MAX_WAIT)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      vic_q    <= '0;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      vic_q    <= vic_d;
      starve_q <= starve_d;
      rvalid_q <= read_sel;
      done_q   <= write_sel;
    end
  end

  // Line payload needs no reset: it is only observed while the buffer is FULL
  always_ff @(posedge clk_i) begin
    if (refill_accept) begin
      buf_addr_q <= refill_addr_i;
      buf_data_q <= refill_data_i;
    end
  end

`ifdef SARGANTANA_IDATA_SCHED_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      wr_cnt_q    <= '0;
    end else if (flush_i) begin
      stall_cnt_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      if (fetch_valid_i & ~fetch_ready_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (write_sel)                      wr_cnt_q    <= wr_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_stall_o = stall_cnt_q;
  assign perf_refill_wr_o   = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sargantana_idata_sched.sv
// Self-checking bench for sargantana_idata_sched: scoreboard of expected array writes and fetch read data.
module tb_sargantana_idata_sched;

  localparam int NW = 4;
  localparam int SW = 256;
  localparam int AW = 6;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            fetch_valid_i;
  logic [AW-1:0]   fetch_addr_i;
  logic            fetch_ready_o;
  logic            fetch_rvalid_o;
  logic [NW*SW-1:0] fetch_data_o;
  logic            refill_valid_i;
  logic [AW-1:0]   refill_addr_i;
  logic [SW-1:0]   refill_data_i;
  logic            refill_ready_o;
  logic [NW-1:0]   refill_way_o;
  logic            refill_done_o;
  logic            flush_i;
  logic [NW-1:0]   mem_req_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [SW-1:0]   mem_data_o;
  logic [NW*SW-1:0] mem_data_i;

  sargantana_idata_sched #(
    .ICACHE_N_WAY(NW),
    .SET_WIDHT(SW),
    .ADDR_WIDHT(AW),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_addr_i(fetch_addr_i),
    .fetch_ready_o(fetch_ready_o),
    .fetch_rvalid_o(fetch_rvalid_o),
    .fetch_data_o(fetch_data_o),
    .refill_valid_i(refill_valid_i),
    .refill_addr_i(refill_addr_i),
    .refill_data_i(refill_data_i),
    .refill_ready_o(refill_ready_o),
    .refill_way_o(refill_way_o),
    .refill_done_o(refill_done_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] initv(int w, int s);
    return {8{8'(w), 8'(s), 16'h5A3C}};
  endfunction

  function automatic logic [NW-1:0] onehot(int w);
    return 4'b0001 << w;
  endfunction

  function automatic logic [SW-1:0] rnd256();
    logic [SW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // synchronous array model: one-cycle read latency, per-way write enable
  logic [SW-1:0]    mem [NW][64];
  logic [NW*SW-1:0] mem_rd;
  bit               mem_init = 0;
  assign mem_data_i = mem_rd;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int w = 0; w < NW; w++)
        for (int s = 0; s < 64; s++) mem[w][s] = initv(w, s);
      mem_rd = '0;
      mem_init = 1;
    end
    if (mem_req_o != '0) begin
      if (mem_we_o) begin
        for (int w = 0; w < NW; w++)
          if (mem_req_o[w]) mem[w][mem_addr_o] = mem_data_o;
      end else begin
        for (int w = 0; w < NW; w++) mem_rd[w*SW +: SW] = mem[w][mem_addr_o];
      end
    end
  end

  // reference model and scoreboard
  typedef struct {
    int            way;
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  wr_t              wq[$];
  logic [NW*SW-1:0] rq[$];
  logic [SW-1:0]    golden [NW][64];
  bit               gold_init = 0;
  int               m_ptr = 0;
  int               m_starve = 0;
  bit               m_rv = 0;
  bit               m_done = 0;

  always @(negedge clk) begin
    bit pending, m_we, m_rd;
    wr_t e;
    logic [NW*SW-1:0] row;
    if (!gold_init) begin
      for (int w = 0; w < NW; w++)
        for (int s = 0; s < 64; s++) golden[w][s] = initv(w, s);
      gold_init = 1;
    end
    if (rst_i) begin
      wq.delete();
      rq.delete();
      m_ptr = 0;
      m_starve = 0;
      m_rv = 0;
      m_done = 0;
    end else begin
      pending = wq.size() != 0;
      m_we = pending && !flush_i && (!fetch_valid_i || m_starve == MAX_WAIT);
      m_rd = fetch_valid_i && !m_we && !flush_i;
      check("rvalid", SW'(fetch_rvalid_o), SW'(m_rv));
      check("done", SW'(refill_done_o), SW'(m_done));
      check("we", SW'(mem_we_o), SW'(m_we));
      check("fready", SW'(fetch_ready_o), SW'(m_rd));
      check("rready", SW'(refill_ready_o), SW'(!pending && !flush_i));
      check("rway", SW'(refill_way_o), pending ? SW'(onehot(wq[0].way)) : '0);
      if (m_rv && rq.size() != 0) begin
        row = rq.pop_front();
        for (int w = 0; w < NW; w++)
          check("rdata", fetch_data_o[w*SW +: SW], row[w*SW +: SW]);
      end
      if (m_rd) begin
        check("rd_req", SW'(mem_req_o), SW'(4'hF));
        check("rd_addr", SW'(mem_addr_o), SW'(fetch_addr_i));
        for (int w = 0; w < NW; w++) row[w*SW +: SW] = golden[w][fetch_addr_i];
        rq.push_back(row);
      end else if (m_we) begin
        e = wq.pop_front();
        check("wr_req", SW'(mem_req_o), SW'(onehot(e.way)));
        check("wr_addr", SW'(mem_addr_o), SW'(e.addr));
        check("wr_data", mem_data_o, e.data);
        golden[e.way][e.addr] = e.data;
        m_ptr = (m_ptr + 1) % NW;
      end else begin
        check("idle_req", SW'(mem_req_o), '0);
      end
      if (flush_i || !pending || m_we) m_starve = 0;
      else if (m_starve < MAX_WAIT) m_starve++;
      if (flush_i) begin
        wq.delete();
        m_ptr = 0;
      end else if (refill_valid_i && !pending) begin
        wq.push_back('{m_ptr, refill_addr_i, refill_data_i});
      end
      m_rv = m_rd;
      m_done = m_we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  grants;
    bit  seen;
    rst_i = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_addr_i = '0;
    refill_valid_i = 1'b0;
    refill_addr_i = '0;
    refill_data_i = '0;
    flush_i = 1'b0;
    repeat (3) tick();
    check("rst_rready", SW'(refill_ready_o), SW'(1));
    check("rst_req", SW'(mem_req_o), '0);
    check("rst_we", SW'(mem_we_o), '0);
    check("rst_rvalid", SW'(fetch_rvalid_o), '0);
    check("rst_done", SW'(refill_done_o), '0);
    rst_i = 1'b0;
    tick();

    // single fetch to set 5
    fetch_valid_i = 1'b1;
    fetch_addr_i = 6'h05;
    #1;
    check("t1_req", SW'(mem_req_o), SW'(4'hF));
    check("t1_we", SW'(mem_we_o), '0);
    check("t1_addr", SW'(mem_addr_o), SW'(6'h05));
    tick();
    fetch_valid_i = 1'b0;
    #1;
    check("t1_rvalid", SW'(fetch_rvalid_o), SW'(1));
    check("t1_data", fetch_data_o[SW-1:0], initv(0, 5));
    tick();

    // refill to set 0x0A, fetch idle; the next refill moves to way 1
    refill_valid_i = 1'b1;
    refill_addr_i = 6'h0A;
    refill_data_i = rnd256();
    tick();
    refill_valid_i = 1'b0;
    #1;
    check("t2_req", SW'(mem_req_o), SW'(4'b0001));
    check("t2_we", SW'(mem_we_o), SW'(1));
    check("t2_addr", SW'(mem_addr_o), SW'(6'h0A));
    tick();
    check("t2_done", SW'(refill_done_o), SW'(1));
    refill_valid_i = 1'b1;
    refill_addr_i = 6'h11;
    refill_data_i = rnd256();
    tick();
    refill_valid_i = 1'b0;
    #1;
    check("t2_req2", SW'(mem_req_o), SW'(4'b0010));
    tick();

    // continuous fetch with a buffered refill: write is forced after MAX_WAIT fetches
    fetch_valid_i = 1'b1;
    fetch_addr_i = 6'h0A;
    refill_valid_i = 1'b1;
    refill_addr_i = 6'h0A;
    refill_data_i = rnd256();
    tick();
    refill_valid_i = 1'b0;
    grants = 0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_we_o) begin
        seen = 1;
        break;
      end
      if (fetch_ready_o) grants++;
      @(posedge clk);
      #1;
      fetch_addr_i = 6'($urandom);
    end
    check("t3_forced", SW'(seen), SW'(1));
    check("t3_grants", SW'(grants), SW'(MAX_WAIT));
    check("t3_fready_blk", SW'(fetch_ready_o), '0);
    tick();
    check("t3_resume", SW'(fetch_ready_o), SW'(1));
    fetch_valid_i = 1'b0;
    tick();

    // flush while FULL: write dropped, pointer back to way 0
    refill_valid_i = 1'b1;
    refill_addr_i = 6'h20;
    refill_data_i = rnd256();
    tick();
    refill_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    check("t5_req", SW'(mem_req_o), '0);
    check("t5_we", SW'(mem_we_o), '0);
    tick();
    flush_i = 1'b0;
    #1;
    check("t5_rready", SW'(refill_ready_o), SW'(1));
    check("t5_way", SW'(refill_way_o), '0);
    refill_valid_i = 1'b1;
    refill_addr_i = 6'h21;
    refill_data_i = rnd256();
    tick();
    refill_valid_i = 1'b0;
    #1;
    check("t5_req0", SW'(mem_req_o), SW'(4'b0001));
    tick();

    // five refills from a fresh pointer: ways 0,1,2,3,0
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      refill_valid_i = 1'b1;
      refill_addr_i = 6'($urandom);
      refill_data_i = rnd256();
      tick();
      refill_valid_i = 1'b0;
      #1;
      check("t4_rready_full", SW'(refill_ready_o), '0);
      check("t4_way", SW'(mem_req_o), SW'(onehot(i % NW)));
      tick();
      check("t4_rready_empty", SW'(refill_ready_o), SW'(1));
    end

    // reset with buffer FULL and a read in flight
    refill_valid_i = 1'b1;
    refill_addr_i = 6'h30;
    refill_data_i = rnd256();
    tick();
    refill_valid_i = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_addr_i = 6'h03;
    tick();
    fetch_valid_i = 1'b0;
    #1;
    rst_i = 1'b1;
    #1;
    check("t6_rvalid", SW'(fetch_rvalid_o), '0);
    check("t6_req", SW'(mem_req_o), '0);
    check("t6_we", SW'(mem_we_o), '0);
    check("t6_rready", SW'(refill_ready_o), SW'(1));
    tick();
    tick();
    rst_i = 1'b0;
    repeat (5) tick();

    // randomized traffic, occasional flush
    for (int c = 0; c < 300; c++) begin
      fetch_valid_i = ($urandom_range(0, 2) != 0);
      fetch_addr_i = 6'($urandom);
      refill_valid_i = ($urandom_range(0, 1) != 0);
      refill_addr_i = 6'($urandom);
      refill_data_i = rnd256();
      flush_i = ($urandom_range(0, 31) == 0);
      tick();
    end
    fetch_valid_i = 1'b0;
    refill_valid_i = 1'b0;
    flush_i = 1'b0;
    repeat (8) tick();
    check("drain_wq", SW'(wq.size()), '0);
    check("drain_rq", SW'(rq.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
